snn_pe_packetizer: RTL

- Clocked injection stage that sits directly upstream of the NoC tree at one endpoint: PE0/1/2, Adder or Mem.
- Accepts result words from the local compute unit, each with a multicast destination set.
- Buffers accepted words and emits one 39-bit tree packet per destination, in the format [38:8] data, [7:4] source address, [3:0] destination address.
- Output is valid/ready, consumed by the clocked-to-channel bridge that drives the tree's *_out channel.

---
 rtl/snn_pe_packetizer_pkg.sv | 57 +++++
 rtl/snn_pe_packetizer_if.sv | 32 +++
 rtl/snn_pe_packetizer_fifo.sv | 52 +++++
 rtl/snn_pe_packetizer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/snn_pe_packetizer_pkg.sv
// snn_noc_pkg: shared constants and types for the tree-injection packetizer.
//   - packet geometry (DATA_W, ADDR_W, PKT_W, field LSB positions)
//   - endpoint index enum and the endpoint address lookup table
//   - packetizer FSM state enum
//   - lowest_idx(): priority pick of the lowest set bit of a destination mask
//   - dest_addr(): endpoint index to 4-bit tree address
package snn_noc_pkg;

    localparam int DATA_W = 31;
    localparam int ADDR_W = 4;
    localparam int PKT_W  = DATA_W + 2 * ADDR_W;
    localparam int N_DEST = 5;
    localparam int IDX_W  = 3;

    localparam int PKT_DST_LSB  = 0;
    localparam int PKT_SRC_LSB  = ADDR_W;
    localparam int PKT_DATA_LSB = 2 * ADDR_W;

    typedef enum logic [IDX_W-1:0] {
        EP_MEM   = 3'd0,
        EP_PE0   = 3'd1,
        EP_PE1   = 3'd2,
        EP_PE2   = 3'd3,
        EP_ADDER = 3'd4
    } ep_idx_t;

    // Element [i] is the tree address of endpoint index i (Mem sits at [0]).
    localparam logic [N_DEST-1:0][ADDR_W-1:0] ADDR = {
        4'b0010,    // Adder
        4'b0000,    // PE2
        4'b0001,    // PE1
        4'b0100,    // PE0
        4'b1000     // Mem
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } pkt_state_t;

    // Scanning from the top down leaves the lowest set bit as the winner.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_DEST-1:0] m);
        lowest_idx = '0;
        for (int i = N_DEST - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    function automatic logic [ADDR_W-1:0] dest_addr(input logic [IDX_W-1:0] idx);
        dest_addr = '0;
        for (int i = 0; i < N_DEST; i++) begin
            if (idx == IDX_W'(i)) dest_addr = ADDR[i];
        end
    endfunction

endpackage

// File: rtl/snn_pe_packetizer_if.sv
// snn_pe_packetizer_if: input word handshake and output packet handshake of
// the packetizer.
//   in_valid/in_ready/in_data/in_dest_mask : compute unit -> packetizer
//   out_valid/out_ready/out_pkt            : packetizer -> channel bridge
// Modports: slave = packetizer view, master = compute unit + bridge view.
interface snn_pe_packetizer_if #(
    parameter int DATA_W = snn_noc_pkg::DATA_W,
    parameter int N_DEST = snn_noc_pkg::N_DEST
);
    import snn_noc_pkg::*;

    localparam int PW = DATA_W + 2 * ADDR_W;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [N_DEST-1:0] in_dest_mask;
    logic              out_valid;
    logic              out_ready;
    logic [PW-1:0]     out_pkt;

    modport slave (
        input  in_valid, in_data, in_dest_mask, out_ready,
        output in_ready, out_valid, out_pkt
    );

    modport master (
        output in_valid, in_data, in_dest_mask, out_ready,
        input  in_ready, out_valid, out_pkt
    );

endinterface

// File: rtl/snn_pe_packetizer_fifo.sv
// pkt_fifo: synchronous FIFO, W bits wide, DEPTH entries (power of 2, >= 2).
// Ports:
//   clk, rst_n     clock, async active-low reset (empties the FIFO)
//   push, din      write request and data (ignored when full)
//   pop, dout      read request (ignored when empty); dout shows the head
//   full, empty    status
//   count          occupancy, 0..DEPTH
module pkt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    // The extra MSB on each pointer separates the full and empty cases.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/snn_pe_packetizer.sv
// snn_pe_packetizer: tree injection stage for one NoC endpoint. Buffers result
// words with a multicast destination mask and emits one packet per
// destination: [38:8] data, [7:4] SRC_ADDR, [3:0] destination address.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus          snn_pe_packetizer_if.slave (input words, output packets)
//   busy         FIFO non-empty or FSM not idle
//   drop_cnt     words discarded because only this endpoint (or nobody) was
//                addressed; saturates at 255
module snn_pe_packetizer #(
    parameter int         DATA_W   = snn_noc_pkg::DATA_W,
    parameter int         N_DEST   = snn_noc_pkg::N_DEST,
    parameter int         DEPTH    = 4,
    parameter int         SELF_IDX = 1,
    parameter logic [3:0] SRC_ADDR = 4'b0100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    snn_pe_packetizer_if.slave   bus,
    output logic                 busy,
    output logic [7:0]           drop_cnt
);
    import snn_noc_pkg::*;

    localparam int FW = DATA_W + N_DEST;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [N_DEST-1:0] SELF_BIT = N_DEST'(1) << SELF_IDX;

    pkt_state_t        state, state_nx;
    logic [DATA_W-1:0] work_data;
    logic [N_DEST-1:0] work_mask;

    logic              fifo_full, fifo_empty, fifo_pop;
    logic [FW-1:0]     fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              push_fire;
    logic [DATA_W-1:0] head_data;
    logic [N_DEST-1:0] head_mask;

    logic [IDX_W-1:0]  send_idx;
    logic [N_DEST-1:0] send_bit;
    logic [N_DEST-1:0] remaining;
    logic              load_en, drop_inc, accept;

    assign push_fire = bus.in_valid && !fifo_full;
    assign bus.in_ready = !fifo_full;

    pkt_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_fire),
        .din   ({bus.in_dest_mask, bus.in_data}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_data = fifo_dout[DATA_W-1:0];
    assign head_mask = fifo_dout[DATA_W +: N_DEST] & ~SELF_BIT;

    assign send_idx  = lowest_idx(work_mask);
    assign send_bit  = N_DEST'(1) << send_idx;
    assign remaining = work_mask & ~send_bit;

    always_comb begin
        state_nx = state;
        fifo_pop = 1'b0;
        load_en  = 1'b0;
        drop_inc = 1'b0;
        accept   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                fifo_pop = 1'b1;
                load_en  = 1'b1;
                if (head_mask == '0) begin
                    drop_inc = 1'b1;
                    // Occupancy after this pop, including a word arriving now.
                    if ((fifo_count > CW'(1)) || push_fire) state_nx = ST_LOAD;
                    else                                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.out_ready) begin
                    accept = 1'b1;
                    if (remaining == '0) state_nx = fifo_empty ? ST_IDLE : ST_LOAD;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            work_data <= '0;
            work_mask <= '0;
            drop_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (load_en) begin
                work_data <= head_data;
                work_mask <= head_mask;
            end else if (accept) begin
                work_mask <= remaining;
            end
            if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Outputs come from registered state only, so they hold until accepted
    // and never follow out_ready combinationally.
    assign bus.out_valid = (state == ST_SEND);
    assign bus.out_pkt   = (state == ST_SEND) ? {work_data, SRC_ADDR, dest_addr(send_idx)} : '0;
    assign busy          = !fifo_empty || (state != ST_IDLE);

endmodule
